blink_sequencer: RTL

- Consumes the free-running 16-bit count from the clock counter stage; sits alongside the blinker and drives the remaining uo_out LED pins.
- Steps through a programmable 8-entry LED pattern table, one step per rising edge of a selectable count bit.
- Supports one-shot or looping playback, plus hold and stop controls.

---
 rtl/blink_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/blink_sequencer.sv
// -----------------------------------------------------------------------------
// blink_sequencer
//
// Plays an 8-entry LED pattern table onto the LED pins, one step per rising
// edge of a selectable bit of the free-running count from the counter stage.
// Playback can be one-shot (stop after the last step) or looping (wrap to
// step 0). It can be frozen with hold and aborted with stop.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst            synchronous reset, active-high
//   current_count  free-running count bus from the counter stage
//   tap_sel        selects the count bit whose rising edge advances a step
//   wr_en          pattern table write strobe (accepted in any state)
//   wr_addr        pattern table write address
//   wr_data        pattern table write data
//   length         index of the last step, sampled when playback starts
//   loop_en        1 = wrap to step 0 after the last step, 0 = one-shot
//   start          begin or restart playback at step 0
//   stop           abort playback and return to idle
//   hold           freeze at the current step while high
//   led            displayed pattern (registered, 0 while idle)
//   step_idx       current step index (registered)
//   busy           high while running or holding (registered)
//   step_pulse     one-cycle pulse when the index advances or wraps
//   done           one-cycle pulse when one-shot playback completes
// -----------------------------------------------------------------------------
module blink_sequencer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] current_count,
  input  logic [3:0]       tap_sel,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [2:0]       length,
  input  logic             loop_en,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  output logic [WIDTH-1:0] led,
  output logic [2:0]       step_idx,
  output logic             busy,
  output logic             step_pulse,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Pattern table and playback registers
  logic [WIDTH-1:0] tbl_q [DEPTH];
  state_t           state_q,  state_d;
  logic [2:0]       idx_q,    idx_d;
  logic [2:0]       last_q,   last_d;
  logic             loop_q,   loop_d;
  logic             tap_prev_q;
  logic [WIDTH-1:0] led_q,    led_d;
  logic             busy_q,   busy_d;
  logic             pulse_q,  pulse_d;
  logic             done_q,   done_d;

  // Step event detection
  logic tap_bit_s;
  logic step_evt_s;

  // Returns true when the index sits on the final programmed step.
  function automatic logic at_last(input logic [2:0] idx, input logic [2:0] last);
    return (idx == last);
  endfunction

  // Tapped count bit and its rising-edge detect against last cycle's sample.
  // Changing tap_sel may produce one spurious event; that is tolerated.
  always_comb begin
    tap_bit_s  = current_count[tap_sel];
    step_evt_s = tap_bit_s & ~tap_prev_q;
  end

  // Next-state and next-output decode; priority is stop > start > hold > step.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    loop_d  = loop_q;
    pulse_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          idx_d   = 3'd0;
          last_d  = length;
          loop_d  = loop_en;
        end else begin
          state_d = ST_IDLE;
          idx_d   = 3'd0;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          idx_d   = 3'd0;
        end else if (start) begin
          // Restart: back to step 0 with freshly sampled settings, no pulse.
          state_d = ST_RUN;
          idx_d   = 3'd0;
          last_d  = length;
          loop_d  = loop_en;
        end else if (hold) begin
          // Entering hold swallows any step event in the same cycle.
          state_d = ST_HOLD;
        end else if (step_evt_s) begin
          if (!at_last(idx_q, last_q)) begin
            idx_d   = idx_q + 3'd1;
            pulse_d = 1'b1;
          end else if (loop_q) begin
            idx_d   = 3'd0;
            pulse_d = 1'b1;
          end else begin
            // One-shot completion reports done only, never step_pulse.
            state_d = ST_IDLE;
            idx_d   = 3'd0;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_HOLD: begin
        if (stop) begin
          state_d = ST_IDLE;
          idx_d   = 3'd0;
        end else if (start) begin
          state_d = ST_RUN;
          idx_d   = 3'd0;
          last_d  = length;
          loop_d  = loop_en;
        end else if (!hold) begin
          // Release cycle: resume running but drop any event seen now.
          state_d = ST_RUN;
        end else begin
          // Events during hold are dropped rather than queued.
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
        last_d  = 3'd0;
        loop_d  = 1'b0;
      end
    endcase

    // The LED reads the table as it was before any write on this edge, so a
    // write to the displayed entry shows up one edge later.
    if (state_d == ST_IDLE) begin
      led_d = {WIDTH{1'b0}};
    end else begin
      led_d = tbl_q[idx_d];
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Pattern table storage; writes are independent of playback state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_en) begin
      tbl_q[wr_addr] <= wr_data;
    end
  end

  // Sequencer FSM with registered outputs and tap history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      last_q     <= 3'd0;
      loop_q     <= 1'b0;
      tap_prev_q <= 1'b0;
      led_q      <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      pulse_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      loop_q     <= loop_d;
      tap_prev_q <= tap_bit_s;
      led_q      <= led_d;
      busy_q     <= busy_d;
      pulse_q    <= pulse_d;
      done_q     <= done_d;
    end
  end

  assign led        = led_q;
  assign step_idx   = idx_q;
  assign busy       = busy_q;
  assign step_pulse = pulse_q;
  assign done       = done_q;

endmodule
